// File: rtl/wb_commit_if.sv
// Memory-stage to write-back/commit handshake bundle: instruction and beat
// inputs plus the registered register-file write port and retire status.
interface wb_commit_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
);
  localparam int NREG = 2**AW;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [AW-1:0]     in_dest;
  logic [DATA_W-1:0] in_data;
  logic [NREG-1:0]   in_mask;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic              beat_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_redirect;
  logic              retire;
  logic [CNT_W-1:0]  retire_count;
  logic              busy;

  modport master (
    output in_valid, in_op, in_dest, in_data, in_mask, beat_valid, beat_data,
    input  in_ready, beat_ready, rf_we, rf_addr, rf_wdata, pc_redirect,
           retire, retire_count, busy
  );

  modport slave (
    input  in_valid, in_op, in_dest, in_data, in_mask, beat_valid, beat_data,
    output in_ready, beat_ready, rf_we, rf_addr, rf_wdata, pc_redirect,
           retire, retire_count, busy
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: single writes, load-multiple bursts in ascending
// register order, PC-write redirect flag and a wrapping retire counter.
//
// state   | meaning
// IDLE    | accepting one instruction per cycle
// MULTI   | load-multiple in flight, one register written per beat
module wb_commit_unit #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
) (
  input logic      clk,
  input logic      resetn,
  wb_commit_if.slave bus
);
  localparam int NREG = 2**AW;

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  count_q;
  logic [AW-1:0]     low_idx;
  logic              last_bit;

  always_comb begin
    low_idx = '0;
    for (int i = NREG-1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = AW'(i);
    end
  end

  // only one bit left means this beat completes the burst
  assign last_bit = ((pend_q & (pend_q - NREG'(1))) == '0);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    retire_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          unique case (bus.in_op)
            2'b01: begin
              we_d     = 1'b1;
              addr_d   = bus.in_dest;
              wdata_d  = bus.in_data;
              retire_d = 1'b1;
            end
            2'b10: begin
              if (bus.in_mask != '0) begin
                pend_d  = bus.in_mask;
                state_d = S_MULTI;
              end else begin
                retire_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_MULTI: begin
        if (bus.beat_valid) begin
          we_d    = 1'b1;
          addr_d  = low_idx;
          wdata_d = bus.beat_data;
          pend_d  = pend_q & ~(NREG'(1) << low_idx);
          if (last_bit) begin
            state_d  = S_IDLE;
            retire_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
      count_q  <= count_q + CNT_W'(retire_d);
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.beat_ready   = (state_q == S_MULTI);
  assign bus.busy         = (state_q == S_MULTI);
  assign bus.rf_we        = we_q;
  assign bus.rf_addr      = addr_q;
  assign bus.rf_wdata     = wdata_q;
  assign bus.retire       = retire_q;
  assign bus.retire_count = count_q;
  assign bus.pc_redirect  = we_q && (addr_q == AW'(NREG-1));
endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: stimulus pushes expected write/retire
// events, an independent monitor pops and compares whenever the DUT reports one.
module tb_wb_commit_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_commit_if #(.DATA_W(16), .AW(3), .CNT_W(16)) bus ();
  wb_commit_unit #(.DATA_W(16), .AW(3), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        ret;
    logic        redir;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_count = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic we, input logic [2:0] addr, input logic [15:0] data,
                          input logic ret);
    exp_t e;
    if (ret) exp_count = exp_count + 16'h1;
    e.we = we; e.addr = addr; e.data = data; e.ret = ret;
    e.redir = we && (addr == 3'd7);
    e.cnt = exp_count;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] dest, input logic [15:0] data,
                       input logic [7:0] mask);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_dest = dest;
    bus.in_data = data; bus.in_mask = mask;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic beat(input logic [15:0] data);
    bus.beat_valid = 1'b1; bus.beat_data = data;
    cyc();
    bus.beat_valid = 1'b0;
  endtask

  // monitor: any write or retire the DUT presents must match the next expectation
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1 || bus.retire === 1'b1) begin
      exp_t e;
      logic ok;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL spurious_output: got we=%0b addr=%0d data=%0h ret=%0b expected none",
                 bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.retire);
      end else begin
        e = sb.pop_front();
        ok = (bus.rf_we === e.we) && (bus.retire === e.ret) &&
             (bus.pc_redirect === e.redir) && (bus.retire_count === e.cnt) &&
             (!e.we || (bus.rf_addr === e.addr && bus.rf_wdata === e.data));
        if (ok) n_pass++;
        else $display("FAIL wb_event: got we=%0b addr=%0d data=%0h ret=%0b redir=%0b cnt=%0h expected we=%0b addr=%0d data=%0h ret=%0b redir=%0b cnt=%0h",
                      bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.retire, bus.pc_redirect,
                      bus.retire_count, e.we, e.addr, e.data, e.ret, e.redir, e.cnt);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_dest = 3'd0; bus.in_data = 16'h0;
    bus.in_mask = 8'h0; bus.beat_valid = 1'b0; bus.beat_data = 16'h0;
    repeat (3) cyc();
    resetn = 1'b1;
    cyc();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_beat_ready", 32'(bus.beat_ready), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_count", 32'(bus.retire_count), 32'd0);

    // single write
    push_exp(1'b1, 3'd3, 16'hBEEF, 1'b1);
    issue(2'b01, 3'd3, 16'hBEEF, 8'h00);
    chk("single_count", 32'(bus.retire_count), 32'd1);

    // load-multiple with gaps; in_valid held during the burst must be ignored
    issue(2'b10, 3'd0, 16'h0, 8'hA5);
    chk("lm_busy", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_dest = 3'd6; bus.in_data = 16'hDEAD;
    begin
      logic [2:0]  regs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
      logic [15:0] vals [4] = '{16'h11, 16'h22, 16'h33, 16'h44};
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk("lm_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("lm_beat_ready", 32'(bus.beat_ready), 32'd1);
        push_exp(1'b1, regs[i], vals[i], i == 3);
        beat(vals[i]);
      end
    end
    bus.in_valid = 1'b0;
    chk("lm_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("lm_count", 32'(bus.retire_count), 32'd2);

    // empty mask retires with no write; bubble and reserved do nothing
    push_exp(1'b0, 3'd0, 16'h0, 1'b1);
    issue(2'b10, 3'd0, 16'h0, 8'h00);
    chk("mask0_in_ready", 32'(bus.in_ready), 32'd1);
    issue(2'b00, 3'd1, 16'h1234, 8'hFF);
    issue(2'b11, 3'd2, 16'h5678, 8'hFF);
    cyc();
    chk("noop_count", 32'(bus.retire_count), 32'd3);

    // beats in IDLE are ignored
    bus.beat_valid = 1'b1; bus.beat_data = 16'h9999;
    chk("idle_beat_ready", 32'(bus.beat_ready), 32'd0);
    repeat (3) cyc();
    bus.beat_valid = 1'b0;

    // reset in the middle of a 4-register burst
    issue(2'b10, 3'd0, 16'h0, 8'h0F);
    push_exp(1'b1, 3'd0, 16'hA0, 1'b0);
    beat(16'hA0);
    push_exp(1'b1, 3'd1, 16'hA1, 1'b0);
    beat(16'hA1);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    exp_count = 16'h0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("midrst_count", 32'(bus.retire_count), 32'd0);
    bus.beat_valid = 1'b1; bus.beat_data = 16'hA2;
    repeat (2) cyc();
    bus.beat_valid = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);

    // wrap the retire counter with back-to-back single writes
    for (int i = 0; i < 65535; i++) begin
      push_exp(1'b1, 3'(i), 16'(i), 1'b1);
      bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_dest = 3'(i); bus.in_data = 16'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("count_full", 32'(bus.retire_count), 32'hFFFF);
    push_exp(1'b1, 3'd4, 16'hCAFE, 1'b1);
    issue(2'b01, 3'd4, 16'hCAFE, 8'h00);
    chk("count_wrap", 32'(bus.retire_count), 32'h0000);

    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Parametrised, registered write-back and commit stage for the IITB RISC pipeline. It accepts one retiring instruction per cycle from the memory stage and drives the register-file write port. It sequences load-multiple instructions as a burst of register writes, consuming one memory beat per register. It flags PC (top register) writes for redirect and keeps a retired-instruction counter.

## Interface
- DATA_W, 16, register/data width
- AW, 3, register address width; NREG = 2**AW registers, register NREG-1 is the PC
- CNT_W, 16, width of retire counter

- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  unit can accept; high only in IDLE
- in_op  in  2  00 bubble, 01 single write, 10 load-multiple, 11 reserved
- in_dest  in  AW  destination register (op 01)
- in_data  in  DATA_W  write data (op 01)
- in_mask  in  NREG  register mask, bit i = write Ri (op 10)
- beat_valid  in  1  load-multiple data beat available
- beat_data  in  DATA_W  load-multiple beat data
- beat_ready  out  1  beat consumed this cycle; high only in MULTI
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  AW  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- pc_redirect  out  1  rf_we high and rf_addr == NREG-1
- retire  out  1  one-cycle pulse per retired instruction (registered)
- retire_count  out  CNT_W  total retired instructions, wraps modulo 2**CNT_W
- busy  out  1  state == MULTI

## Operation
- States: IDLE, MULTI. Accept = in_valid & in_ready. Beat = beat_valid & beat_ready.
- IDLE, accept, op 01: next cycle rf_we=1, rf_addr=in_dest, rf_wdata=in_data, retire=1. Stay IDLE.
- IDLE, accept, op 10, in_mask != 0: latch mask into pend_mask, go MULTI, no write this cycle.
- IDLE, accept, op 10, in_mask == 0: retire=1 next cycle, no write, stay IDLE.
- IDLE, accept, op 00 or 11: consumed, no write, no retire.
- MULTI, beat: target i = lowest set bit of pend_mask. Next cycle rf_we=1, rf_addr=i, rf_wdata=beat_data. Clear bit i.
- MULTI, beat clears the last bit: go IDLE, and retire=1 together with that final write.
- MULTI, no beat: rf_we=0, state and mask hold. Writes are always in ascending register order.
- in_valid in MULTI is ignored (in_ready=0). beat_valid in IDLE is ignored (beat_ready=0).
- retire_count increments on every retire pulse and wraps from all-ones to 0.
- pc_redirect is combinational from the registered rf_we/rf_addr. It is never asserted without rf_we.

## Timing
- Reset values: state IDLE, pend_mask 0, rf_we 0, rf_addr 0, rf_wdata 0, retire 0, retire_count 0, pc_redirect 0, busy 0, beat_ready 0, in_ready 1 (from cycle after reset).
- Reset mid-burst: abandons the burst and does not retire. Outputs take reset values the next edge.
- in_ready and beat_ready are decoded from state only. Neither depends on in_valid or beat_valid.
- Latency: accept/beat at edge t, write visible rf_we at t+1 for exactly one cycle.
- Throughput: op 01 back-to-back every cycle. An op 10 with k mask bits set occupies in_ready low for k beat cycles plus stalls. in_ready rises the cycle after the final beat.
- Bubble or reserved op consumes one accept slot with zero outputs.

## Test plan
- Reset, then op 01 dest=3 data=0xBEEF: the cycle after accept shows rf_we=1, rf_addr=3, rf_wdata=0xBEEF, retire=1, retire_count=1.
- Op 10 mask=0b10100101, beats 0x11,0x22,0x33,0x44 with gaps: writes R0=0x11, R2=0x22, R5=0x33, R7=0x44 in order. pc_redirect=1 only on the R7 write. Single retire with the last write. in_ready low throughout.
- Op 10 mask=0: no write, retire=1, in_ready stays high. In the same run, op 00 and op 11 give no write and no retire.
- Assert resetn low after the second beat of a 4-bit burst: state IDLE, no further writes, retire_count=0.
- Preload retire_count to 0xFFFF via 65535 op 01 retires, then one more: count wraps to 0x0000.
- Drive in_valid during MULTI and beat_valid in IDLE: both are ignored, with no spurious writes.
